// File: rtl/cplx_pkg.sv
// Shared types and helpers for the complex adder/accumulator.
package cplx_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ACC_W_DEF  = 48;
    localparam int unsigned LEN_W_DEF  = 16;
    localparam int unsigned MAX_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_e;

    // Signed range limits of a w-bit value, returned at MAX_W; callers truncate to w.
    function automatic logic signed [MAX_W-1:0] acc_max(input int unsigned w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic signed [MAX_W-1:0] acc_min(input int unsigned w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/cplx_sat_add.sv
// One signed ACC_W adder; saturates and flags overflow when CPLX_ACC_SAT_EN is defined,
// otherwise wraps modulo 2^ACC_W with the overflow flag tied low.
module cplx_sat_add
    import cplx_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W-1:0] b_i,
    output logic signed [ACC_W-1:0] sum_c_o,
    output logic                    ovf_c_o
);

`ifdef CPLX_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

    logic [ACC_W:0] full;

    // One guard bit: overflow when the two top bits disagree.
    always_comb begin
        full    = {a_i[ACC_W-1], a_i} + {b_i[ACC_W-1], b_i};
        ovf_c_o = full[ACC_W] ^ full[ACC_W-1];
        sum_c_o = full[ACC_W-1:0];
        if (ovf_c_o) begin
            sum_c_o = full[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum_c_o = a_i + b_i;
    assign ovf_c_o = 1'b0;
`endif

endmodule

// File: rtl/cplx_accum.sv
// Complex pairwise adder / frame accumulator with valid/ready handshakes.
// Define CPLX_ACC_SAT_EN for saturating adds and a live out_ovf flag.
module cplx_accum
    import cplx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     mode,
    input  logic [LEN_W-1:0]         frame_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_re,
    output logic signed [ACC_W-1:0]  out_im,
    output logic                     out_ovf
);

    localparam int unsigned EXT_W = ACC_W - DATA_W;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d, len_q, len_d;
    logic                     ovf_q, ovf_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0]  a_re_x, a_im_x, b_re_x, b_im_x;
    logic signed [ACC_W-1:0]  s_re, s_im, acc_re_sum, acc_im_sum;
    logic                     s_re_ovf, s_im_ovf, acc_re_ovf, acc_im_ovf;
    logic [LEN_W-1:0]         len_in, cnt_inc;
    logic                     beat;

    assign a_re_x = {{EXT_W{a_re[DATA_W-1]}}, a_re};
    assign a_im_x = {{EXT_W{a_im[DATA_W-1]}}, a_im};
    assign b_re_x = {{EXT_W{b_re[DATA_W-1]}}, b_re};
    assign b_im_x = {{EXT_W{b_im[DATA_W-1]}}, b_im};

    // Beat sum s = a + b per component.
    cplx_sat_add #(.ACC_W(ACC_W)) u_beat_re (.a_i(a_re_x), .b_i(b_re_x), .sum_c_o(s_re), .ovf_c_o(s_re_ovf));
    cplx_sat_add #(.ACC_W(ACC_W)) u_beat_im (.a_i(a_im_x), .b_i(b_im_x), .sum_c_o(s_im), .ovf_c_o(s_im_ovf));

    // Accumulate path acc + s per component.
    cplx_sat_add #(.ACC_W(ACC_W)) u_acc_re (.a_i(acc_re_q), .b_i(s_re), .sum_c_o(acc_re_sum), .ovf_c_o(acc_re_ovf));
    cplx_sat_add #(.ACC_W(ACC_W)) u_acc_im (.a_i(acc_im_q), .b_i(s_im), .sum_c_o(acc_im_sum), .ovf_c_o(acc_im_ovf));

    assign in_ready = (state_q != HOLD) || out_ready;
    assign beat     = in_valid && in_ready;
    assign len_in   = (frame_len == '0) ? LEN_W'(1) : frame_len;
    assign cnt_inc  = cnt_q + LEN_W'(1);

    always_comb begin
        state_d  = state_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, HOLD: begin
                if (state_q == HOLD && out_ready) begin
                    state_d = IDLE;
                end
                // A beat taken while the result drains starts a fresh frame.
                if (beat) begin
                    acc_re_d = s_re;
                    acc_im_d = s_im;
                    ovf_d    = s_re_ovf | s_im_ovf;
                    len_d    = len_in;
                    cnt_d    = LEN_W'(1);
                    state_d  = (!mode || len_in == LEN_W'(1)) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_re_d = acc_re_sum;
                    acc_im_d = acc_im_sum;
                    ovf_d    = ovf_q | s_re_ovf | s_im_ovf | acc_re_ovf | acc_im_ovf;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = HOLD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d  = IDLE;
            acc_re_d = '0;
            acc_im_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end

        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            cnt_q       <= '0;
            len_q       <= LEN_W'(1);
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = acc_re_q;
    assign out_im    = acc_im_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cplx_accum.sv
// Bench for cplx_accum at ACC_W = DATA_W+1: directed cases plus random traffic vs a frame-level model.
module tb_cplx_accum;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 33;
    localparam int unsigned LW = 16;
    localparam longint AMAX = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (AW - 1));

    logic                 clk = 1'b0;
    logic                 rst_n, clr, mode, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [LW-1:0]        frame_len;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [AW-1:0] out_re, out_im;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint re;
        longint im;
        bit     ovf;
    } res_t;

    res_t   exp_q[$];
    bit     in_frame;
    bit     mon_en;
    int     rem;
    longint m_re, m_im;
    bit     m_ovf;

    always #5 clk = ~clk;

    cplx_accum #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reduce an exact sum to the ACC_W result the build is meant to produce.
    function automatic longint fold(input longint r, inout bit ovf);
`ifdef CPLX_ACC_SAT_EN
        if (r > AMAX) begin ovf = 1'b1; return AMAX; end
        if (r < AMIN) begin ovf = 1'b1; return AMIN; end
        return r;
`else
        logic signed [AW-1:0] t;
        t = AW'(r);
        ovf = ovf;
        return longint'(t);
`endif
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        in_frame = 1'b0;
    endfunction

    function automatic void model_beat();
        bit     o = 1'b0;
        longint sr, si;
        sr = fold(longint'(a_re) + longint'(b_re), o);
        si = fold(longint'(a_im) + longint'(b_im), o);
        if (!in_frame) begin
            rem      = mode ? ((frame_len == 0) ? 1 : int'(frame_len)) : 1;
            m_re     = sr;
            m_im     = si;
            m_ovf    = o;
            in_frame = 1'b1;
        end else begin
            m_re  = fold(m_re + sr, o);
            m_im  = fold(m_im + si, o);
            m_ovf = m_ovf | o;
        end
        rem--;
        if (rem == 0) begin
            exp_q.push_back('{re: m_re, im: m_im, ovf: m_ovf});
            in_frame = 1'b0;
        end
    endfunction

    // Scoreboard: sample on the falling edge what the next rising edge will act on.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", longint'(out_valid), (exp_q.size() != 0) ? 1 : 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_re", longint'(out_re), exp_q[0].re);
                chk("out_im", longint'(out_im), exp_q[0].im);
                chk("out_ovf", longint'(out_ovf), longint'(exp_q[0].ovf));
            end
            chk("in_ready", longint'(in_ready), (exp_q.size() == 0 || out_ready) ? 1 : 0);
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (clr) model_clear();
            else if (in_valid && in_ready) model_beat();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; clr = 1'b0; mode = 1'b0; frame_len = LW'(1);
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    endtask

    task automatic rand_in();
        in_valid  = ($urandom_range(0, 9) < 6);
        clr       = ($urandom_range(0, 49) == 0);
        mode      = 1'($urandom_range(0, 1));
        frame_len = LW'($urandom_range(0, 4));
        out_ready = ($urandom_range(0, 9) < 7);
        a_re = $urandom; a_im = $urandom; b_re = $urandom; b_im = $urandom;
    endtask

    task automatic beat(input longint ar, input longint ai, input longint br, input longint bi);
        a_re = DW'(ar); a_im = DW'(ai); b_re = DW'(br); b_im = DW'(bi);
        in_valid = 1'b1;
    endtask

    longint pr, pi, qr, qi;
    longint acc_re_v[4] = '{1, 2, 3, 4};
    longint acc_im_v[4] = '{1, -1, 0, 5};

    initial begin
        mon_en = 1'b0;
        in_frame = 1'b0;
        rst_n = 1'b0;
        idle_in();
        out_ready = 1'b1;

        // Reset held with random inputs.
        repeat (4) begin
            rand_in();
            #1;
            chk("rst_valid", longint'(out_valid), 0);
            chk("rst_re", longint'(out_re), 0);
            chk("rst_im", longint'(out_im), 0);
            chk("rst_ready", longint'(in_ready), 1);
            step();
        end
        idle_in();
        out_ready = 1'b1;
        rst_n = 1'b1;
        model_clear();
        mon_en = 1'b1;
        step();

        // First pairwise beat.
        mode = 1'b0;
        beat(3, -4, 5, 2);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("pw1_valid", longint'(out_valid), 1);
        chk("pw1_re", longint'(out_re), 8);
        chk("pw1_im", longint'(out_im), -2);
        out_ready = 1'b1;
        step();
        chk("pw1_drained", longint'(out_valid), 0);

        // Pairwise streaming, one result per cycle.
        for (int i = 0; i < 10; i++) begin
            pr = longint'($signed($urandom)); pi = longint'($signed($urandom));
            qr = longint'($signed($urandom)); qi = longint'($signed($urandom));
            beat(pr, pi, qr, qi);
            step();
            chk("stream_valid", longint'(out_valid), 1);
            chk("stream_re", longint'(out_re), pr + qr);
            chk("stream_im", longint'(out_im), pi + qi);
        end
        in_valid = 1'b0;
        step();

        // Accumulate 4 beats with gaps; later beats carry mode/len that must be ignored.
        for (int i = 0; i < 4; i++) begin
            mode = (i == 0);
            frame_len = (i == 0) ? LW'(4) : LW'(1);
            beat(acc_re_v[i], acc_im_v[i], 0, 0);
            step();
            in_valid = 1'b0;
            if (i < 3) begin
                chk("acc_early", longint'(out_valid), 0);
                step();
                chk("acc_gap", longint'(out_valid), 0);
            end else begin
                chk("acc_valid", longint'(out_valid), 1);
                chk("acc_re", longint'(out_re), 10);
                chk("acc_im", longint'(out_im), 5);
            end
        end
        step();

        // Backpressure, then consume and start a new frame in the same cycle.
        mode = 1'b0;
        out_ready = 1'b0;
        beat(7, 7, 1, 1);
        step();
        beat(100, -50, 1, 1);
        repeat (5) begin
            #1;
            chk("bp_ready", longint'(in_ready), 0);
            chk("bp_re", longint'(out_re), 8);
            chk("bp_im", longint'(out_im), 8);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", longint'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("bp_new_valid", longint'(out_valid), 1);
        chk("bp_new_re", longint'(out_re), 101);
        chk("bp_new_im", longint'(out_im), -49);
        step();

        // Overflow: three beats of max-positive operands.
        mode = 1'b1;
        frame_len = LW'(3);
        repeat (3) begin
            beat(32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0);
            step();
        end
        in_valid = 1'b0;
        chk("ovf_valid", longint'(out_valid), 1);
`ifdef CPLX_ACC_SAT_EN
        chk("ovf_re", longint'(out_re), (longint'(1) <<< 32) - 1);
        chk("ovf_flag", longint'(out_ovf), 1);
`else
        chk("ovf_re", longint'(out_re), (longint'(1) <<< 32) - 6);
        chk("ovf_flag", longint'(out_ovf), 0);
`endif
        mode = 1'b0;
        beat(1, 1, 1, 1);
        step();
        in_valid = 1'b0;
        chk("ovf_clear", longint'(out_ovf), 0);
        chk("ovf_next_re", longint'(out_re), 2);
        step();

        // clr mid-frame discards the partial sum and the beat presented with it.
        mode = 1'b1;
        frame_len = LW'(4);
        beat(50, 50, 0, 0); step();
        beat(60, 60, 0, 0); step();
        beat(70, 70, 0, 0); clr = 1'b1; step();
        clr = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            chk("clr_quiet", longint'(out_valid), 0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            beat(i + 1, 0, 0, 0);
            step();
        end
        chk("clr_re", longint'(out_re), 10);
        chk("clr_valid", longint'(out_valid), 1);
        frame_len = '0;
        beat(9, 9, 1, 1);
        step();
        in_valid = 1'b0;
        chk("len0_valid", longint'(out_valid), 1);
        chk("len0_re", longint'(out_re), 10);
        step();

        // Asynchronous reset in the middle of a frame.
        frame_len = LW'(4);
        beat(11, 11, 0, 0); step();
        beat(12, 12, 0, 0); step();
        in_valid = 1'b0;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", longint'(out_valid), 0);
        chk("arst_re", longint'(out_re), 0);
        model_clear();
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        step();
        mode = 1'b0;
        beat(5, 5, 5, 5);
        step();
        in_valid = 1'b0;
        chk("arst_fresh_re", longint'(out_re), 10);
        chk("arst_fresh_valid", longint'(out_valid), 1);
        step();

        // Random traffic against the scoreboard.
        repeat (3000) begin
            rand_in();
            step();
        end
        idle_in();
        out_ready = 1'b1;
        repeat (3) step();
        chk("drain_valid", longint'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
